// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and the divider state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, trial-subtract the divisor, restore on borrow.
module div_step #(
  parameter int SIZE = 8
) (
  input  logic [SIZE:0]   r,
  input  logic [SIZE-1:0] q,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   r_next,
  output logic [SIZE-1:0] q_next
);

  logic [SIZE+1:0] t;
  logic [SIZE+1:0] diff;

  // One guard bit above the shifted remainder keeps the borrow exact even when
  // the shifted value itself reaches SIZE+1 bits.
  always_comb begin
    t    = {r, q[SIZE-1]};
    diff = t - {2'b00, b};
    if (diff[SIZE+1]) begin
      r_next = t[SIZE:0];
      q_next = {q[SIZE-2:0], 1'b0};
    end else begin
      r_next = diff[SIZE:0];
      q_next = {q[SIZE-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with
// quotient/remainder returned alongside a single-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; results hold the last division
// CALC  | one shift/subtract iteration per edge, cnt counts down to 1
// DONE  | done pulse; results valid from here on
module seq_divider
  import alu_pkg::*;
#(
  parameter int SIZE = ALU_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] q,
  output logic [SIZE-1:0] r,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CW = $clog2(SIZE + 1);

  div_state_t      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [SIZE:0]   rem, rem_nxt;
  logic [SIZE-1:0] quo, quo_nxt;
  logic [SIZE-1:0] dvs;
  logic            accept;
  logic            last_iter;

  div_step #(.SIZE(SIZE)) u_step (
    .r      (rem),
    .q      (quo),
    .b      (dvs),
    .r_next (rem_nxt),
    .q_next (quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) begin
          last_iter = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Outputs move only when entering DONE; div_by_zero also clears on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      quo         <= a;
      dvs         <= b;
      rem         <= '0;
      cnt         <= CW'(SIZE);
      div_by_zero <= 1'b0;
      if (b == '0) begin
        q           <= '1;
        r           <= a;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt - CW'(1);
      if (last_iter) begin
        q <= quo_nxt;
        r <= rem_nxt[SIZE-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a / and % reference,
// using a queue of expected results popped at each done pulse.
module tb_seq_divider;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] q, r;
  logic       busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int accepted = 0;
  exp_t sb[$];
  logic [7:0] last_q = '0;
  logic [7:0] last_r = '0;

  seq_divider #(.SIZE(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic div_op(input logic [7:0] av, input logic [7:0] bv, input int glitch);
    exp_t e, got;
    int   lat;
    bit   seen;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    e.q   = (bv == 0) ? 8'hFF : av / bv;
    e.r   = (bv == 0) ? av : av % bv;
    e.dbz = (bv == 0);
    sb.push_back(e);
    accepted++;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    chk("busy_at_accept", busy, 1);
    chk("dbz_at_accept", div_by_zero, (bv == 0));
    lat = 1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      chk("q_hold", q, last_q);
      chk("r_hold", r, last_r);
      if (lat == glitch) begin start = 1'b1; a = 8'd50; b = 8'd3; end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, (bv == 0) ? 1 : 9);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("q", q, got.q);
      chk("r", r, got.r);
      chk("dbz", div_by_zero, got.dbz);
      last_q = got.q; last_r = got.r;
    end
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  initial begin
    int base;
    #2;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    div_op(8'd200, 8'd7, 0);
    div_op(8'd255, 8'd1, 0);
    div_op(8'd5,   8'd9, 0);
    div_op(8'd0,   8'd3, 0);
    div_op(8'd100, 8'd0, 0);
    div_op(8'd200, 8'd7, 0);
    base = done_cnt;
    div_op(8'd200, 8'd7, 4);
    @(posedge clk); #1;
    chk("single_done", done_cnt - base, 1);

    // Abort mid-CALC with an asynchronous reset.
    @(negedge clk);
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", div_by_zero, 0);
    base = done_cnt;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - base, 0);
    last_q = '0; last_r = '0;
    div_op(8'd81, 8'd9, 0);

    div_op(8'd0,   8'd0,   0);
    div_op(8'd255, 8'd255, 0);
    div_op(8'd255, 8'd129, 0);
    div_op(8'd254, 8'd255, 0);
    div_op(8'd255, 8'd128, 0);
    div_op(8'd1,   8'd255, 0);
    for (int i = 0; i < 400; i++)
      div_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);

    @(posedge clk); #1;
    chk("done_count", done_cnt, accepted);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
